// File: rtl/prog_accel_top.sv
// prog_accel_top: three-task accelerator (SECDED encode, SECDED decode, 5-bit pattern count)
// sequenced by req/ack over a 256x8 memory with async read and sync write.
module prog_accel_mem (
  input  logic       clk,
  input  logic       we_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o
);
  logic [7:0] core [256];
  always_ff @(posedge clk) if (we_i) core[addr_i] <= wdata_i;
  assign rdata_o = core[addr_i];
endmodule

module prog_accel_top (
  input  logic req,
  input  logic clk,
  output logic ack,
  input  logic reset
);
  typedef enum logic [2:0] {IDLE, RUN1, RUN2, RUN3, DONE} state_e;
  state_e      st_q;
  logic [1:0]  nxt_q, ph_q;
  logic [5:0]  idx_q;
  logic [7:0]  lo_q, hi_q, c_in_q, c_byte_q, c_all_q;
  logic [4:0]  pat_q;
  logic [3:0]  prev_q;
  logic [7:0]  rdata, wdata, addr, off;
  logic        we;
  logic [11:1] d;
  logic        p1, p2, p4, p8, p16;
  logic [15:0] w, wc;
  logic [3:0]  syn;
  logic        par, de;
  logic [11:0] x;
  logic [2:0]  n_in, n_x;

  prog_accel_mem data_mem1 (.clk(clk), .we_i(we), .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata));

  assign d   = {hi_q[2:0], lo_q};
  assign p8  = ^d[11:5];
  assign p4  = ^d[11:8] ^ d[4] ^ d[3] ^ d[2];
  assign p2  = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
  assign p1  = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
  assign p16 = ^d ^ p8 ^ p4 ^ p2 ^ p1;

  // Syndrome bit j covers every Hamming position whose index has bit j set
  assign w   = {hi_q, lo_q};
  assign syn = {^(w & 16'hFF00), ^(w & 16'hF0F0), ^(w & 16'hCCCC), ^(w & 16'hAAAA)};
  assign par = ^w;
  assign de  = !par && |syn;
  assign wc  = (par && |syn) ? w ^ (16'd1 << syn) : w;

  // Windows i=0..3 lie inside the current byte, i=4..7 straddle the previous one
  assign x = {prev_q, rdata};
  always_comb begin
    n_in = 3'd0;
    n_x  = 3'd0;
    for (int i = 0; i < 8; i++)
      if (x[i+:5] == pat_q) begin
        if (i < 4) n_in = n_in + 3'd1;
        else n_x = n_x + 3'd1;
      end
  end

  always_comb begin
    off   = ph_q == 2'd0 ? 8'd0 : ph_q == 2'd1 ? 8'd1 : ph_q == 2'd2 ? 8'd30 : 8'd31;
    addr  = st_q == RUN3 ? (ph_q == 2'd0 ? 8'd160 : ph_q == 2'd1 ? 8'd128 + {2'b0, idx_q} : 8'd192 + {2'b0, idx_q})
                         : {1'b0, idx_q, 1'b0} + off + (st_q == RUN2 ? 8'd64 : 8'd0);
    we    = (st_q == RUN1 || st_q == RUN2) ? ph_q[1] : (st_q == RUN3 && ph_q == 2'd2);
    wdata = st_q == RUN3 ? (idx_q == 6'd0 ? c_in_q : idx_q == 6'd1 ? c_byte_q : c_all_q)
          : st_q == RUN1 ? (ph_q[0] ? {d[11:5], p8} : {d[4], d[3], d[2], p4, d[1], p2, p1, p16})
          : (ph_q[0] ? {de, 4'b0, wc[15:13]} : {wc[12:9], wc[7:5], wc[3]});
  end

  always_ff @(posedge clk)
    if (!reset) begin
      st_q     <= IDLE;
      nxt_q    <= 2'd1;
      ack      <= 1'b0;
      ph_q     <= 2'd0;
      idx_q    <= 6'd0;
      c_in_q   <= 8'd0;
      c_byte_q <= 8'd0;
      c_all_q  <= 8'd0;
    end else
      case (st_q)
        IDLE, DONE:
          if (req) begin
            st_q  <= nxt_q == 2'd1 ? RUN1 : nxt_q == 2'd2 ? RUN2 : RUN3;
            ack   <= 1'b0;
            ph_q  <= 2'd0;
            idx_q <= 6'd0;
          end
        RUN1, RUN2: begin
          ph_q <= ph_q + 2'd1;
          if (ph_q == 2'd0) lo_q <= rdata;
          if (ph_q == 2'd1) hi_q <= rdata;
          if (ph_q == 2'd3) begin
            idx_q <= idx_q + 6'd1;
            if (idx_q == 6'd14) begin
              st_q  <= DONE;
              ack   <= 1'b1;
              nxt_q <= st_q == RUN1 ? 2'd2 : 2'd3;
            end
          end
        end
        RUN3:
          if (ph_q == 2'd0) begin
            pat_q    <= rdata[4:0];
            c_in_q   <= 8'd0;
            c_byte_q <= 8'd0;
            c_all_q  <= 8'd0;
            ph_q     <= 2'd1;
          end else if (ph_q == 2'd1) begin
            c_in_q   <= c_in_q + {5'd0, n_in};
            c_byte_q <= c_byte_q + {7'd0, |n_in};
            c_all_q  <= c_all_q + {5'd0, n_in} + (idx_q == 6'd0 ? 8'd0 : {5'd0, n_x});
            prev_q   <= rdata[3:0];
            idx_q    <= idx_q == 6'd31 ? 6'd0 : idx_q + 6'd1;
            if (idx_q == 6'd31) ph_q <= 2'd2;
          end else begin
            idx_q <= idx_q + 6'd1;
            if (idx_q == 6'd2) begin
              st_q  <= DONE;
              ack   <= 1'b1;
              nxt_q <= 2'd1;
            end
          end
        default: st_q <= IDLE;
      endcase
endmodule

// File: tb/tb_prog_accel_top.sv
// tb_prog_accel_top: randomized and directed checks of prog_accel_top against a
// position-based Hamming model and a bit-stream window counter.
module tb_prog_accel_top;
  logic clk = 1'b0, req = 1'b0, reset = 1'b0;
  logic ack;
  int pass = 0, fails = 0, total = 0;
  logic [10:0] d1 [15];
  logic [15:0] w2 [15];
  logic [7:0]  s3 [32];
  logic [4:0]  pat3;
  logic [15:0] t2 [4] = '{16'h020F, 16'h000E, 16'h000F, 16'h060F};
  int sent [5] = '{60, 124, 161, 191, 195};

  prog_accel_top dut (.req(req), .clk(clk), .ack(ack), .reset(reset));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [10:0] dv);
    logic [15:0] w = '0;
    int j = 0, s = 0;
    for (int k = 3; k < 16; k++) if ((k & (k - 1)) != 0) begin w[k] = dv[j]; j++; end
    for (int k = 1; k < 16; k++) if (w[k]) s ^= k;
    for (int b = 0; b < 4; b++) w[1 << b] = s[b];
    w[0] = ^w[15:1];
    return w;
  endfunction

  // Returns {status byte, data byte} as the decoder should write them
  function automatic logic [15:0] dec(input logic [15:0] wi);
    logic [15:0] w = wi;
    logic [10:0] dv = '0;
    int s = 0, j = 0;
    logic dbl = 1'b0;
    for (int k = 1; k < 16; k++) if (w[k]) s ^= k;
    if (^w) begin
      if (s != 0) w[s] = ~w[s];
    end else dbl = (s != 0);
    for (int k = 3; k < 16; k++) if ((k & (k - 1)) != 0) begin dv[j] = w[k]; j++; end
    return {dbl, 4'b0, dv[10:8], dv[7:0]};
  endfunction

  function automatic logic [4:0] win(input logic [255:0] sb, input int p);
    logic [4:0] v = '0;
    for (int q = 0; q < 5; q++) v = {v[3:0], sb[p+q]};
    return v;
  endfunction

  task automatic model3(output int ci, output int cb, output int ca);
    logic [255:0] sb;
    for (int b = 0; b < 32; b++) for (int t = 0; t < 8; t++) sb[8*b+t] = s3[b][7-t];
    ci = 0; cb = 0; ca = 0;
    for (int p = 0; p < 252; p++) if (win(sb, p) == pat3) ca++;
    for (int b = 0; b < 32; b++) begin
      int any = 0;
      for (int t = 0; t < 4; t++) if (win(sb, 8*b+t) == pat3) begin ci++; any = 1; end
      cb += any;
    end
  endtask

  task automatic fill1(input int mode);
    logic [31:0] r, r2;
    for (int i = 0; i < 15; i++) begin
      r = $urandom; r2 = $urandom;
      d1[i] = (mode == 0 && i < 3) ? (i == 0 ? 11'h001 : i == 1 ? 11'h7FF : 11'h000) : r[10:0];
      dut.data_mem1.core[2*i]   = d1[i][7:0];
      dut.data_mem1.core[2*i+1] = {r2[4:0], d1[i][10:8]};
    end
  endtask

  task automatic fill2(input int mode);
    logic [31:0] r;
    logic [15:0] w;
    for (int i = 0; i < 15; i++) begin
      r = $urandom;
      w = enc(r[10:0]);
      for (int f = 0; f < int'($urandom_range(0, 2)); f++) w[$urandom_range(0, 15)] ^= 1'b1;
      w2[i] = (mode == 0 && i < 4) ? t2[i] : w;
      dut.data_mem1.core[64+2*i] = w2[i][7:0];
      dut.data_mem1.core[65+2*i] = w2[i][15:8];
    end
  endtask

  task automatic fill3(input int mode);
    logic [31:0] r;
    r = $urandom;
    pat3 = mode == 0 ? 5'b00000 : mode == 1 ? 5'b10101 : mode == 2 ? 5'b11111 : r[4:0];
    dut.data_mem1.core[160] = {r[7:5], pat3};
    for (int b = 0; b < 32; b++) begin
      r = $urandom;
      s3[b] = mode == 1 ? 8'h55 : mode == 3 ? (r[8] ? r[7:0] : {r[7:5], pat3}) : 8'h00;
      dut.data_mem1.core[128+b] = s3[b];
    end
  endtask

  task automatic run_task(input int n, input int hold);
    int cyc = 0, ci, cb, ca;
    logic [15:0] e;
    @(posedge clk); #1 req = 1'b1;
    @(posedge clk); #1;
    chk($sformatf("t%0d ack_fall", n), ack, 0);
    for (int c = 1; c < hold; c++) begin @(posedge clk); #1; end
    req = 1'b0;
    while (!ack && cyc < 1024) begin @(posedge clk); #1; cyc++; end
    chk($sformatf("t%0d ack_rise", n), ack, 1);
    @(posedge clk); #1;
    chk($sformatf("t%0d ack_hold", n), ack, 1);
    if (n == 1)
      for (int i = 0; i < 15; i++) begin
        e = enc(d1[i]);
        chk($sformatf("t1 lo[%0d]", i), dut.data_mem1.core[30+2*i], e[7:0]);
        chk($sformatf("t1 hi[%0d]", i), dut.data_mem1.core[31+2*i], e[15:8]);
      end
    else if (n == 2)
      for (int i = 0; i < 15; i++) begin
        e = dec(w2[i]);
        chk($sformatf("t2 lo[%0d]", i), dut.data_mem1.core[94+2*i], e[7:0]);
        chk($sformatf("t2 hi[%0d]", i), dut.data_mem1.core[95+2*i], e[15:8]);
      end
    else begin
      model3(ci, cb, ca);
      chk("t3 c_in", dut.data_mem1.core[192], ci);
      chk("t3 c_byte", dut.data_mem1.core[193], cb);
      chk("t3 c_all", dut.data_mem1.core[194], ca);
    end
    for (int s = 0; s < 5; s++) chk($sformatf("sentinel[%0d]", sent[s]), dut.data_mem1.core[sent[s]], 8'hA5);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst ack", ack, 0);
    reset = 1'b1;
    for (int s = 0; s < 5; s++) dut.data_mem1.core[sent[s]] = 8'hA5;
    fill1(0); run_task(1, 1);
    chk("t1 d001 lo", dut.data_mem1.core[30], 8'h0F);
    chk("t1 d001 hi", dut.data_mem1.core[31], 8'h00);
    chk("t1 d7ff lo", dut.data_mem1.core[32], 8'hFF);
    chk("t1 d7ff hi", dut.data_mem1.core[33], 8'hFF);
    chk("t1 d000 lo", dut.data_mem1.core[34], 8'h00);
    fill2(0); run_task(2, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t2 dir lo[%0d]", i), dut.data_mem1.core[94+2*i], 8'h01);
      chk($sformatf("t2 dir hi[%0d]", i), dut.data_mem1.core[95+2*i], 8'h00);
    end
    chk("t2 dbl flag", dut.data_mem1.core[101][7], 1);
    chk("t2 dbl zeros", dut.data_mem1.core[101][6:3], 0);
    fill3(0); run_task(3, 2);
    chk("t3 zero in", dut.data_mem1.core[192], 128);
    chk("t3 zero byte", dut.data_mem1.core[193], 32);
    chk("t3 zero all", dut.data_mem1.core[194], 252);
    fill1(1); run_task(1, 4);
    fill2(1); run_task(2, 1);
    fill3(1); run_task(3, 1);
    chk("t3 alt in", dut.data_mem1.core[192], 64);
    chk("t3 alt byte", dut.data_mem1.core[193], 32);
    chk("t3 alt all", dut.data_mem1.core[194], 126);
    fill1(1); run_task(1, 1);
    fill2(1); run_task(2, 1);
    fill3(2); run_task(3, 1);
    chk("t3 ones in", dut.data_mem1.core[192], 0);
    chk("t3 ones byte", dut.data_mem1.core[193], 0);
    chk("t3 ones all", dut.data_mem1.core[194], 0);
    for (int k = 0; k < 3; k++) begin
      fill1(1); run_task(1, 1);
      fill2(1); run_task(2, 1);
      fill3(3); run_task(3, 1);
    end
    fill1(1); run_task(1, 1);
    fill2(1);
    @(posedge clk); #1 req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    chk("abort ack", ack, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("abort ack idle", ack, 0);
    fill1(1); run_task(1, 1);
    fill2(1); run_task(2, 1);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
